alu_cmd_driver: RTL and testbench

- Initiator-side controller for the 2-bit ALU datapath: accepts operation commands on a valid/ready interface and drives the ALU's A, B and sel inputs.
- Samples the ALU's 4-bit Y output and returns tagged results through a result FIFO with valid/ready.
- Supports repeat commands that sweep operand A, so a bench or upstream sequencer can exercise the ALU without per-cycle control.

---
 rtl/alu_cmd_driver_pkg.sv | 33 +++
 rtl/alu_cmd_driver_if.sv | 46 ++++
 rtl/alu_cmd_driver_fifo.sv | 61 ++++++
 rtl/alu_cmd_driver.sv | 151 +++++++++++++++
 tb/tb_alu_cmd_driver.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_cmd_driver_pkg.sv
// Shared types for the ALU command driver.
//   alu_op_e     : ALU opcodes as carried on cmd_sel / alu_sel
//   drv_state_e  : issue FSM state encoding
//   res_entry_t  : one result FIFO entry {y, tag, last}
//   next_a       : operand-A sweep step (wraps 3 -> 0)
package alu_drv_pkg;

  typedef enum logic [1:0] {
    OP_INV  = 2'b00,
    OP_NAND = 2'b01,
    OP_ADD  = 2'b10,
    OP_MUL  = 2'b11
  } alu_op_e;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } drv_state_e;

  // Widest tag a driver instance may use; narrower tags occupy the low bits.
  localparam int unsigned TAG_W_MAX = 8;

  typedef struct packed {
    logic [3:0]           y;
    logic [TAG_W_MAX-1:0] tag;
    logic                 last;
  } res_entry_t;

  function automatic logic [1:0] next_a(input logic [1:0] a);
    return a + 2'd1;
  endfunction

endpackage

// File: rtl/alu_cmd_driver_if.sv
// Bus bundle between the ALU command driver and its environment.
//   cmd_* : command channel (valid/ready) into the driver
//   alu_* : operands/opcode to the ALU, alu_y back from it
//   res_* : result channel (valid/ready) out of the driver
// Modports: master = the driver, slave = sequencer/ALU/consumer side.
interface alu_cmd_driver_if #(
  parameter int unsigned TAG_W = 2
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_a;
  logic [1:0]       cmd_b;
  logic [1:0]       cmd_sel;
  logic [1:0]       cmd_rep;
  logic [TAG_W-1:0] cmd_tag;

  logic [1:0]       alu_a;
  logic [1:0]       alu_b;
  logic [1:0]       alu_sel;
  logic [3:0]       alu_y;

  logic             res_valid;
  logic             res_ready;
  logic [3:0]       res_y;
  logic [TAG_W-1:0] res_tag;
  logic             res_last;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_rep, cmd_tag,
    output cmd_ready,
    output alu_a, alu_b, alu_sel,
    input  alu_y,
    output res_valid, res_y, res_tag, res_last,
    input  res_ready
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_rep, cmd_tag,
    input  cmd_ready,
    input  alu_a, alu_b, alu_sel,
    output alu_y,
    input  res_valid, res_y, res_tag, res_last,
    output res_ready
  );

endinterface

// File: rtl/alu_cmd_driver_fifo.sv
// alu_drv_fifo: synchronous result FIFO with count-based full/empty.
//   clk, rst_n : clock, synchronous active-low reset (clears contents too)
//   push_i     : write wdata_i (caller only pushes when !full_o or popping)
//   pop_i      : advance head (caller only pops when !empty_o)
//   rdata_o    : head entry, straight from the storage registers
//   count_o    : occupancy, full_o / empty_o derived from it
// Depth must be a power of two >= 2 so the pointers wrap naturally.
module alu_drv_fifo
  import alu_drv_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  res_entry_t      wdata_i,
  input  logic            pop_i,
  output res_entry_t      rdata_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o
);

  res_entry_t      mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      // Cleared so the registered head reads zero straight out of reset.
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: initiator-side controller for the 2-bit ALU datapath.
// Accepts commands, drives ALU operands (sweeping A for repeats), captures
// alu_y each issue cycle and queues tagged results in a FIFO.
//   clk, rst_n  : clock, synchronous active-low reset
//   bus         : alu_cmd_driver_if.master (cmd_*, alu_*, res_* channels)
//   busy        : FSM not idle or results still queued
// Build option ALU_CMD_DRIVER_CHECKSUM_EN adds:
//   chk_clr (in) : clear the checksum (wins over a pop that cycle)
//   chk     (out): 8-bit running sum of popped res_y, wraps mod 256
module alu_cmd_driver
  import alu_drv_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TAG_W      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_cmd_driver_if.master bus,
  output logic             busy
`ifdef ALU_CMD_DRIVER_CHECKSUM_EN
  ,
  input  logic             chk_clr,
  output logic [7:0]       chk
`endif
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  drv_state_e       state_q;
  logic [1:0]       a_q;
  logic [1:0]       b_q;
  alu_op_e          sel_q;
  logic [TAG_W-1:0] tag_q;
  logic [1:0]       rem_q;

  logic             cmd_rdy;
  logic             cmd_fire;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CntW-1:0]  fifo_count;
  res_entry_t       push_entry;
  res_entry_t       head;

  assign pop  = !fifo_empty && bus.res_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push = (state_q == ST_ISSUE) && (!fifo_full || pop);

  // ISSUE may chain the next command only on its final push, and only if a
  // slot is left for that command's first result after this push.
  always_comb begin
    cmd_rdy = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        ST_IDLE:  cmd_rdy = !fifo_full;
        ST_ISSUE: cmd_rdy = (rem_q == 2'd0) && (fifo_count < CntW'(FIFO_DEPTH - 1));
        default:  cmd_rdy = 1'b0;
      endcase
    end
  end

  assign cmd_fire = bus.cmd_valid && cmd_rdy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= OP_INV;
      tag_q   <= '0;
      rem_q   <= '0;
    end else if (cmd_fire) begin
      // Reached from IDLE, or from ISSUE on its final (guaranteed) push.
      state_q <= ST_ISSUE;
      a_q     <= bus.cmd_a;
      b_q     <= bus.cmd_b;
      sel_q   <= alu_op_e'(bus.cmd_sel);
      tag_q   <= bus.cmd_tag;
      rem_q   <= bus.cmd_rep;
    end else begin
      unique case (state_q)
        ST_IDLE: state_q <= ST_IDLE;
        ST_ISSUE: begin
          // No push means the FIFO is full: hold operands and rem.
          if (push) begin
            if (rem_q != 2'd0) begin
              a_q   <= next_a(a_q);
              rem_q <= rem_q - 2'd1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    push_entry                 = '0;
    push_entry.y               = bus.alu_y;
    push_entry.tag[TAG_W-1:0]  = tag_q;
    push_entry.last            = (rem_q == 2'd0);
  end

  alu_drv_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.cmd_ready = cmd_rdy;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_sel   = sel_q;
  assign bus.res_valid = !fifo_empty;
  assign bus.res_y     = head.y;
  assign bus.res_tag   = head.tag[TAG_W-1:0];
  assign bus.res_last  = head.last;
  assign busy          = (state_q != ST_IDLE) || !fifo_empty;

  // Tag bits above TAG_W are always zero in the FIFO.
  logic unused_head_tag;
  assign unused_head_tag = ^head.tag;

`ifdef ALU_CMD_DRIVER_CHECKSUM_EN
  logic [7:0] chk_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chk_q <= '0;
    end else if (chk_clr) begin
      chk_q <= '0;
    end else if (pop) begin
      chk_q <= chk_q + {4'b0000, head.y};
    end
  end

  assign chk = chk_q;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Self-checking bench for alu_cmd_driver: directed steps plus randomized
// commands, checked against a queue-based model of the expected results.
module tb_alu_cmd_driver;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;

  always #5 clk = ~clk;

  alu_cmd_driver_if #(.TAG_W(2)) bus ();

`ifdef ALU_CMD_DRIVER_CHECKSUM_EN
  logic       chk_clr;
  logic [7:0] chk;
`endif

  alu_cmd_driver #(
    .FIFO_DEPTH (4),
    .TAG_W      (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .busy    (busy)
`ifdef ALU_CMD_DRIVER_CHECKSUM_EN
    ,
    .chk_clr (chk_clr),
    .chk     (chk)
`endif
  );

  // ALU behaviour: 00 invert A, 01 nand, 10 add, 11 multiply.
  function automatic logic [3:0] alu_ref(input logic [1:0] a, input logic [1:0] b,
                                         input logic [1:0] sel);
    int r;
    case (sel)
      2'b00:   r = 3 - int'(a);
      2'b01:   r = 3 - (int'(a) & int'(b));
      2'b10:   r = int'(a) + int'(b);
      default: r = int'(a) * int'(b);
    endcase
    return 4'(r);
  endfunction

  // Stand-in for the ALU itself.
  assign bus.alu_y = alu_ref(bus.alu_a, bus.alu_b, bus.alu_sel);

  typedef struct {
    logic [3:0] y;
    logic [1:0] tag;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   pops = 0;
  int   exp_total = 0;
  bit   fired = 0;
  bit   rand_ready = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes at negedge, step past posedge, update model.
  task automatic tick();
    bit         cf;
    bit         rf;
    logic [1:0] ca, cb, cs, cr, ct;
    logic [3:0] ry;
    logic [1:0] rt;
    logic       rl;
    exp_t       e;
    @(negedge clk);
    cf = rst_n && bus.cmd_valid && bus.cmd_ready;
    rf = rst_n && bus.res_valid && bus.res_ready;
    ca = bus.cmd_a; cb = bus.cmd_b; cs = bus.cmd_sel; cr = bus.cmd_rep; ct = bus.cmd_tag;
    ry = bus.res_y; rt = bus.res_tag; rl = bus.res_last;
    @(posedge clk);
    #1;
    fired = cf;
    if (rf) begin
      pops++;
      check("res_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("res_y", ry, e.y);
        check("res_tag", rt, e.tag);
        check("res_last", rl, e.last);
      end
    end
    if (cf) begin
      for (int i = 0; i <= int'(cr); i++) begin
        e.y    = alu_ref(2'((int'(ca) + i) % 4), cb, cs);
        e.tag  = ct;
        e.last = (i == int'(cr));
        exp_q.push_back(e);
        exp_total++;
      end
    end
    if (rand_ready) bus.res_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_fire(input int bound, input string tag);
    int n;
    n = 0;
    fired = 0;
    while (!fired && n < bound) begin
      tick();
      n++;
    end
    bus.cmd_valid = 1'b0;
    check({tag, "_accepted"}, 32'(fired), 1);
  endtask

  task automatic send(input logic [1:0] a, input logic [1:0] b, input logic [1:0] sel,
                      input logic [1:0] rep, input logic [1:0] tag);
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_sel   = sel;
    bus.cmd_rep   = rep;
    bus.cmd_tag   = tag;
    bus.cmd_valid = 1'b1;
    wait_fire(64, "cmd");
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.res_valid) && n < bound) begin
      tick();
      n++;
    end
    check("drain_done", 32'(exp_q.size() == 0 && !bus.res_valid), 1);
    check("drain_busy", busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] bp_a [6];
    logic [1:0] bp_b [6];
    int         mul_y [4];
    int         pops_before;
    mul_y = '{6, 9, 0, 3};

    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_sel   = '0;
    bus.cmd_rep   = '0;
    bus.cmd_tag   = '0;
    bus.res_ready = 1'b0;
`ifdef ALU_CMD_DRIVER_CHECKSUM_EN
    chk_clr = 1'b0;
`endif

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_alu_b", bus.alu_b, 0);
    check("rst_alu_sel", bus.alu_sel, 0);
    check("rst_res_y", bus.res_y, 0);
    check("rst_res_tag", bus.res_tag, 0);
    check("rst_res_last", bus.res_last, 0);
`ifdef ALU_CMD_DRIVER_CHECKSUM_EN
    check("rst_chk", chk, 0);
`endif
    rst_n = 1'b1;
    #1;
    check("idle_cmd_ready", bus.cmd_ready, 1);

    // Single add: 3 + 2, result one cycle after accept.
    bus.res_ready = 1'b1;
    send(2'd3, 2'd2, 2'b10, 2'd0, 2'd1);
    check("add_alu_a", bus.alu_a, 3);
    check("add_alu_b", bus.alu_b, 2);
    check("add_alu_sel", bus.alu_sel, 2);
    check("add_res_valid_early", bus.res_valid, 0);
    check("add_busy", busy, 1);
    tick();
    check("add_res_valid", bus.res_valid, 1);
    check("add_res_y", bus.res_y, 5);
    check("add_res_tag", bus.res_tag, 1);
    check("add_res_last", bus.res_last, 1);
    tick();
    check("add_res_valid_after", bus.res_valid, 0);
    check("add_busy_after", busy, 0);

    // Repeat multiply with A wrapping 2,3,0,1.
    send(2'd2, 2'd3, 2'b11, 2'd3, 2'd2);
    check("mul_alu_a0", bus.alu_a, 2);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("mul_res_y", bus.res_y, mul_y[i-1]);
      check("mul_res_last", bus.res_last, 32'(i == 4));
      if (i < 4) check("mul_alu_a", bus.alu_a, (2 + i) % 4);
    end
    drain(16);

    // Backpressure: 6 single adds into a 4-deep FIFO with no consumer.
    bus.res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bp_a[i] = 2'($urandom_range(0, 3));
      bp_b[i] = 2'($urandom_range(0, 3));
    end
    for (int i = 0; i < 4; i++) send(bp_a[i], bp_b[i], 2'b10, 2'd0, 2'(i));
    bus.cmd_a     = bp_a[4];
    bus.cmd_b     = bp_b[4];
    bus.cmd_sel   = 2'b10;
    bus.cmd_rep   = 2'd0;
    bus.cmd_tag   = 2'd0;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_cmd_ready", bus.cmd_ready, 0);
      check("bp_not_accepted", 32'(fired), 0);
      check("bp_alu_a_held", bus.alu_a, bp_a[3]);
      check("bp_alu_b_held", bus.alu_b, bp_b[3]);
      check("bp_res_valid", bus.res_valid, 1);
    end
    check("bp_head_tag", bus.res_tag, 0);
    check("bp_head_y", bus.res_y, int'(bp_a[0]) + int'(bp_b[0]));
    pops_before   = pops;
    bus.res_ready = 1'b1;
    wait_fire(64, "bp_cmd4");
    send(bp_a[5], bp_b[5], 2'b10, 2'd0, 2'd1);
    drain(64);
    check("bp_total_results", pops - pops_before, 6);

    // Back-to-back commands, results on consecutive cycles.
    send(2'd1, 2'd1, 2'b10, 2'd0, 2'd0);
    send(2'd1, 2'd2, 2'b11, 2'd0, 2'd1);
    check("b2b_first_valid", bus.res_valid, 1);
    check("b2b_first_tag", bus.res_tag, 0);
    tick();
    check("b2b_second_valid", bus.res_valid, 1);
    check("b2b_second_tag", bus.res_tag, 1);
    tick();
    check("b2b_done", bus.res_valid, 0);

    // Reset during the second repetition of a rep=3 command.
    bus.res_ready = 1'b0;
    send(2'd1, 2'd2, 2'b01, 2'd3, 2'd3);
    tick();
    check("mid_alu_a", bus.alu_a, 2);
    rst_n = 1'b0;
    tick();
    check("mid_rst_res_valid", bus.res_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_alu_a", bus.alu_a, 0);
    check("mid_rst_alu_b", bus.alu_b, 0);
    check("mid_rst_alu_sel", bus.alu_sel, 0);
    check("mid_rst_cmd_ready", bus.cmd_ready, 0);
    exp_total -= exp_q.size();
    exp_q.delete();
    rst_n         = 1'b1;
    bus.res_ready = 1'b1;
    send(2'd1, 2'd2, 2'b00, 2'd1, 2'd2);
    drain(32);

    // Randomized commands with random consumer backpressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 24; n++) begin
      send(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end
    drain(400);
    rand_ready    = 1'b0;
    bus.res_ready = 1'b1;
    check("model_empty", exp_q.size(), 0);
    check("all_results_seen", pops, exp_total);

`ifdef ALU_CMD_DRIVER_CHECKSUM_EN
    chk_clr = 1'b1;
    tick();
    chk_clr = 1'b0;
    check("chk_cleared", chk, 0);
    send(2'd3, 2'd3, 2'b11, 2'd0, 2'd0);
    send(2'd3, 2'd3, 2'b11, 2'd0, 2'd1);
    send(2'd2, 2'd3, 2'b11, 2'd0, 2'd2);
    drain(32);
    check("chk_sum", chk, 24);
    chk_clr = 1'b1;
    tick();
    chk_clr = 1'b0;
    check("chk_clr", chk, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
